cpu_alu_seq: RTL

Parametrised, sequential successor to the 8-bit combinational CPU ALU. It adds configurable datapath width, registered result and flags, and an internal carry flag that feeds ADC/SBC chains. It also adds multi-cycle operations: an iterative shift-add multiply and multi-bit shifts. It sits between the register file and the writeback stage and talks to the control unit through a start/ready/valid handshake.

---
 rtl/cpu_alu_seq_if.sv | 26 ++
 rtl/cpu_alu_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_alu_seq_if.sv
// Control-unit handshake and operand/result bus for cpu_alu_seq.
interface cpu_alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [3:0]       ope;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             z_flag;
    logic             c_flag;
    logic             n_flag;
    logic             v_flag;

    modport master (
        output start, ope, a, b,
        input  ready, valid, result, z_flag, c_flag, n_flag, v_flag
    );

    modport slave (
        input  start, ope, a, b,
        output ready, valid, result, z_flag, c_flag, n_flag, v_flag
    );
endinterface

// File: rtl/cpu_alu_seq.sv
// Sequential CPU ALU: registered result/flags, carry chaining through ADC/SBC,
// iterative shift-add multiply and bit-serial multi-bit shifts.
module cpu_alu_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    cpu_alu_seq_if.slave bus
);
    localparam int unsigned ShW  = $clog2(WIDTH);
    localparam int unsigned CntW = ShW + 1;

    localparam logic [3:0] OpAdd  = 4'd1;
    localparam logic [3:0] OpSub  = 4'd2;
    localparam logic [3:0] OpAnd  = 4'd3;
    localparam logic [3:0] OpOr   = 4'd4;
    localparam logic [3:0] OpAdc  = 4'd5;
    localparam logic [3:0] OpXor  = 4'd6;
    localparam logic [3:0] OpShl  = 4'd7;
    localparam logic [3:0] OpShr  = 4'd8;
    localparam logic [3:0] OpNota = 4'd9;
    localparam logic [3:0] OpNotb = 4'd10;
    localparam logic [3:0] OpSbc  = 4'd11;
    localparam logic [3:0] OpMul  = 4'd12;
    localparam logic [3:0] OpShln = 4'd13;
    localparam logic [3:0] OpShrn = 4'd14;
    localparam logic [3:0] OpCmp  = 4'd15;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               z_q, c_q, n_q, v_q;

    logic               accept, is_mul, is_shn, wr, c_new, v_new;
    logic [ShW-1:0]     shamt;
    logic [WIDTH-1:0]   opb, fv;
    logic               cin, ovf;
    logic [WIDTH:0]     sum, mul_sum;
    logic [2*WIDTH-1:0] step;
    logic               step_out;

    // DONE behaves like IDLE for acceptance so back-to-back starts chain on the new carry
    assign accept = (state_q != StExec) && bus.start;
    assign is_mul = MUL_EN && (bus.ope == OpMul);
    assign is_shn = (bus.ope == OpShln) || (bus.ope == OpShrn);
    assign shamt  = bus.b[ShW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StExec: begin
                if (count_q == CntW'(1)) state_d = StDone;
            end
            default: begin
                state_d = StIdle;
                if (bus.start) begin
                    state_d = (is_mul || (is_shn && shamt != '0)) ? StExec : StDone;
                end
            end
        endcase
    end

    always_comb begin
        bus.ready = (state_q != StExec);
        bus.valid = (state_q == StDone);
    end

    // Single-cycle arithmetic at WIDTH+1 bits
    always_comb begin
        opb = bus.b;
        cin = 1'b0;
        case (bus.ope)
            OpAdc:        cin = c_q;
            OpSub, OpCmp: begin opb = ~bus.b; cin = 1'b1; end
            OpSbc:        begin opb = ~bus.b; cin = c_q; end
            default: ;
        endcase
        sum = {1'b0, bus.a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
        ovf = (bus.a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    end

    // One EXEC iteration; for shifts only the low half of prod_q is live
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{prod_q[0]}}};
        step_out = 1'b0;
        case (op_q)
            OpShln: begin
                step     = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], 1'b0};
                step_out = prod_q[WIDTH-1];
            end
            OpShrn: begin
                step     = {prod_q[2*WIDTH-1:WIDTH], 1'b0, prod_q[WIDTH-1:1]};
                step_out = prod_q[0];
            end
            default: step = {mul_sum, prod_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        prod_d   = prod_q;
        count_d  = count_q;
        result_d = result_q;
        fv       = result_q;
        c_new    = 1'b0;
        v_new    = 1'b0;
        wr       = 1'b0;
        if (accept) begin
            op_d = bus.ope;
            a_d  = bus.a;
            if (is_mul) begin
                prod_d  = {{WIDTH{1'b0}}, bus.b};
                count_d = CntW'(WIDTH);
            end else if (is_shn && shamt != '0) begin
                prod_d  = {{WIDTH{1'b0}}, bus.a};
                count_d = {1'b0, shamt};
            end else begin
                wr = 1'b1;
                case (bus.ope)
                    OpAdd, OpAdc, OpSub, OpSbc: begin
                        result_d = sum[WIDTH-1:0];
                        c_new    = sum[WIDTH];
                        v_new    = ovf;
                    end
                    OpCmp: begin
                        c_new = sum[WIDTH];
                        v_new = ovf;
                    end
                    OpAnd:          result_d = bus.a & bus.b;
                    OpOr:           result_d = bus.a | bus.b;
                    OpXor:          result_d = bus.a ^ bus.b;
                    OpShl:          result_d = {bus.a[WIDTH-2:0], 1'b0};
                    OpShr:          result_d = {1'b0, bus.a[WIDTH-1:1]};
                    OpNota:         result_d = ~bus.a;
                    OpNotb:         result_d = ~bus.b;
                    OpShln, OpShrn: result_d = bus.a;
                    default:        result_d = '0;  // opcode 0, or MUL when not built
                endcase
                fv = (bus.ope == OpCmp) ? sum[WIDTH-1:0] : result_d;
            end
        end else if (state_q == StExec) begin
            prod_d  = step;
            count_d = count_q - CntW'(1);
            if (count_q == CntW'(1)) begin
                wr       = 1'b1;
                result_d = step[WIDTH-1:0];
                fv       = step[WIDTH-1:0];
                if (op_q == OpMul) begin
                    c_new = |step[2*WIDTH-1:WIDTH];
                    v_new = c_new;
                end else begin
                    c_new = step_out;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            prod_q  <= prod_d;
            count_q <= count_d;
            if (wr) begin
                result_q <= result_d;
                z_q      <= (fv == '0);
                c_q      <= c_new;
                n_q      <= fv[WIDTH-1];
                v_q      <= v_new;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.z_flag = z_q;
    assign bus.c_flag = c_q;
    assign bus.n_flag = n_q;
    assign bus.v_flag = v_q;
endmodule
